// File: rtl/lcd_pattern_gen_pkg.sv
// Shared definitions for the LCD pattern generator:
// mode encodings, 24-bit colour constants and the default frame geometry.
package lcd_pattern_gen_pkg;

  localparam int H_ACTIVE_DEFAULT = 800;
  localparam int V_ACTIVE_DEFAULT = 480;
  localparam int CHK_LOG2_DEFAULT = 5;

  typedef enum logic [1:0] {
    MODE_WHITE   = 2'd0,
    MODE_BARS    = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_RAMP    = 2'd3
  } mode_e;

  localparam logic [23:0] RGB_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] RGB_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] RGB_CYAN    = 24'h00FFFF;
  localparam logic [23:0] RGB_GREEN   = 24'h00FF00;
  localparam logic [23:0] RGB_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] RGB_RED     = 24'hFF0000;
  localparam logic [23:0] RGB_BLUE    = 24'h0000FF;
  localparam logic [23:0] RGB_BLACK   = 24'h000000;

  function automatic logic [23:0] gray_rgb(input logic [7:0] level);
    return {level, level, level};
  endfunction

endpackage

// File: rtl/lcd_pattern_gen_if.sv
// Pixel stream between the pattern generator (master) and the LCD sync generator (slave).
interface lcd_pattern_gen_if;

  logic [7:0] r;
  logic [7:0] g;
  logic [7:0] b;
  logic       data_vld;
  logic       data_ready;
  logic       sof;
  logic       eol;

  modport master (
    output r, g, b, data_vld, sof, eol,
    input  data_ready
  );

  modport slave (
    input  r, g, b, data_vld, sof, eol,
    output data_ready
  );

endinterface

// File: rtl/lcd_pattern_gen_bar_lut.sv
// Colour-bar lookup: 3-bit bar index to 24-bit RGB, left (0) to right (7).
module lcd_pattern_gen_bar_lut
  import lcd_pattern_gen_pkg::*;
(
  input  logic [2:0]  bar_idx,
  output logic [23:0] rgb
);

  always_comb begin
    rgb = RGB_BLACK;
    case (bar_idx)
      3'd0:    rgb = RGB_WHITE;
      3'd1:    rgb = RGB_YELLOW;
      3'd2:    rgb = RGB_CYAN;
      3'd3:    rgb = RGB_GREEN;
      3'd4:    rgb = RGB_MAGENTA;
      3'd5:    rgb = RGB_RED;
      3'd6:    rgb = RGB_BLUE;
      default: rgb = RGB_BLACK;
    endcase
  end

endmodule

// File: rtl/lcd_pattern_gen.sv
// Test-pattern pixel source feeding the LCD sync generator over a valid/ready stream.
// Optional red frame border overlay when PATGEN_BORDER_EN is defined.
module lcd_pattern_gen
  import lcd_pattern_gen_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEFAULT,
  parameter int V_ACTIVE = V_ACTIVE_DEFAULT,
  parameter int CHK_LOG2 = CHK_LOG2_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [1:0]        i_mode,
  lcd_pattern_gen_if.master pix
);

  localparam int XW    = $clog2(H_ACTIVE);
  localparam int YW    = $clog2(V_ACTIVE);
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int BW    = $clog2(BAR_W);

  localparam logic [XW-1:0] X_LAST   = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(V_ACTIVE - 1);
  localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]    state;
  mode_e         mode_q;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [2:0]    bar_idx;
  logic [BW-1:0] bar_cnt;

  logic [XW-1:0] nx;
  logic [YW-1:0] ny;
  logic [2:0]    nbar_idx;
  logic [BW-1:0] nbar_cnt;

  logic [XW-1:0] px;
  logic [YW-1:0] py;
  logic [2:0]    pbar_idx;
  logic [BW-1:0] pbar_cnt;
  mode_e         pmode;

  logic          x_last;
  logic          y_last;
  logic          step;
  logic          load;
  logic          chk_odd;
  logic [23:0]   bar_rgb;
  logic [23:0]   pat_rgb;
  logic [23:0]   pix_rgb;

  assign x_last = (x == X_LAST);
  assign y_last = (y == Y_LAST);

  // A fresh pixel is loaded once to prime the stream, then on every accepted transfer.
  assign step = pix.data_vld;
  assign load = (state == S_RUN) && (!pix.data_vld || pix.data_ready);

  always_comb begin
    nx       = x + 1'b1;
    ny       = y;
    nbar_idx = bar_idx;
    nbar_cnt = bar_cnt + 1'b1;
    if (x_last) begin
      nx       = '0;
      ny       = y_last ? '0 : y + 1'b1;
      nbar_idx = '0;
      nbar_cnt = '0;
    end else if (bar_cnt == BAR_LAST) begin
      nbar_idx = bar_idx + 1'b1;
      nbar_cnt = '0;
    end
  end

  // The pixel being generated: the next position when advancing, else the primed origin.
  assign px       = step ? nx       : x;
  assign py       = step ? ny       : y;
  assign pbar_idx = step ? nbar_idx : bar_idx;
  assign pbar_cnt = step ? nbar_cnt : bar_cnt;
  assign pmode    = (step && x_last && y_last) ? mode_e'(i_mode) : mode_q;

  lcd_pattern_gen_bar_lut u_bar_lut (
    .bar_idx (pbar_idx),
    .rgb     (bar_rgb)
  );

  assign chk_odd = 1'(px >> CHK_LOG2) ^ 1'(py >> CHK_LOG2);

  always_comb begin
    pat_rgb = RGB_WHITE;
    case (pmode)
      MODE_WHITE:   pat_rgb = RGB_WHITE;
      MODE_BARS:    pat_rgb = bar_rgb;
      MODE_CHECKER: pat_rgb = chk_odd ? RGB_BLACK : RGB_WHITE;
      MODE_RAMP:    pat_rgb = gray_rgb(8'(px));
      default:      pat_rgb = RGB_WHITE;
    endcase
  end

`ifdef PATGEN_BORDER_EN
  always_comb begin
    pix_rgb = pat_rgb;
    if ((px == '0) || (px == X_LAST) || (py == '0) || (py == Y_LAST)) begin
      pix_rgb = RGB_RED;
    end
  end
`else
  assign pix_rgb = pat_rgb;
`endif

  // Counters always describe the pixel currently held on the outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= S_IDLE;
      mode_q       <= MODE_WHITE;
      x            <= '0;
      y            <= '0;
      bar_idx      <= '0;
      bar_cnt      <= '0;
      pix.r        <= '0;
      pix.g        <= '0;
      pix.b        <= '0;
      pix.data_vld <= 1'b0;
      pix.sof      <= 1'b0;
      pix.eol      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          mode_q <= mode_e'(i_mode);
          state  <= S_RUN;
        end
        default: begin
          if (load) begin
            pix.data_vld            <= 1'b1;
            {pix.r, pix.g, pix.b}   <= pix_rgb;
            pix.sof                 <= (px == '0) && (py == '0);
            pix.eol                 <= (px == X_LAST);
            x                       <= px;
            y                       <= py;
            bar_idx                 <= pbar_idx;
            bar_cnt                 <= pbar_cnt;
            mode_q                  <= pmode;
          end
        end
      endcase
    end
  end

endmodule
